// File: rtl/clkdiv_pkg.sv
// Shared definitions for the blink/clock-divider controller.
//   cfg_state_e : configuration FSM states (IDLE accepts a write, PEND waits for a tick)
//   chan_rec_t  : per-channel state record (div, en, cnt, out)
//   calc_pre    : system clocks per base tick
//   pre_width   : width of the prescaler counter
package clkdiv_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_e;

    typedef struct packed {
        logic [31:0] div;
        logic        en;
        logic [31:0] cnt;
        logic        out;
    } chan_rec_t;

    function automatic int calc_pre(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int pre_width(input int pre);
        return (pre > 1) ? $clog2(pre) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Configuration write port of clkdiv_ctrl (valid/ready handshake).
//   cfg_valid : write request            (master -> slave)
//   cfg_ready : controller accepts write (slave -> master)
//   cfg_ch    : target channel           (master -> slave)
//   cfg_div   : half-period in ticks, 0 disables the channel
//   cfg_en    : channel enable
interface clkdiv_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 16
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel. Counts base ticks and toggles out every div ticks.
//   clk, rst_n : system clock, synchronous active-low reset
//   tick       : prescaler tick pulse
//   load       : apply load_div/load_en this cycle (only asserted on a tick)
//   load_div   : new half-period in ticks
//   load_en    : new enable
//   sync_clr   : clear count and force out low (phase realign, only on a tick)
//   out        : registered divided output
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic             load_en,
    input  logic             sync_clr,
    output logic             out
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             out_q, out_d;
    logic             active;
    logic             load_active;

    always_comb begin
        div_d       = div_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        active      = en_q && (div_q != '0);
        load_active = load_en && (load_div != '0);
        if (load) begin
            // A reload replaces the advance on this tick; the output level is
            // kept only if the channel stays running.
            div_d = load_div;
            en_d  = load_en;
            cnt_d = '0;
            out_d = load_active ? out_q : 1'b0;
        end else if (!active) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (tick) begin
            if (cnt_q == div_q - DIV_W'(1)) begin
                cnt_d = '0;
                out_d = !out_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        if (sync_clr) begin
            cnt_d = '0;
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= DIV_W'(DEF_DIV);
            en_q  <= 1'b1;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            div_q <= div_d;
            en_q  <= en_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Runtime-programmable blink/clock-divider controller: one shared prescaler
// feeding NCH channel dividers, configured through a valid/ready port.
// Writes are held pending and applied on the next prescaler tick so the
// outputs never glitch.
//   clk, rst_n : system clock, synchronous active-low reset
//   cfg        : configuration write port (clkdiv_if.slave)
//   tick       : one-cycle pulse every CLK_HZ/TICK_HZ clocks
//   clkout     : divided outputs, one per channel
// Optional feature: define CLKDIV_PHASE_SYNC_EN to clear every channel's
// count and output on each applied write, realigning all phases.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int NCH     = 4,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    clkdiv_if.slave        cfg,
    output logic           tick,
    output logic [NCH-1:0] clkout
);

    localparam int               PRE      = calc_pre(CLK_HZ, TICK_HZ);
    localparam int               PRE_W    = pre_width(PRE);
    localparam int               CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q, tick_d;
    cfg_state_e       state_q, state_d;
    logic             ready_q, ready_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_en_q, pend_en_d;
    logic             apply;
    logic             sync_clr;
    logic [NCH-1:0]   load;

    always_comb begin
        pre_cnt_d  = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
        // tick is registered, so it is decided from the count the next cycle will hold
        tick_d     = (pre_cnt_d == PRE_LAST);
        state_d    = state_q;
        ready_d    = ready_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        pend_en_d  = pend_en_q;
        apply      = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                // a tick in this same cycle is ignored; the write waits for the next one
                if (cfg.cfg_valid && ready_q) begin
                    pend_ch_d  = cfg.cfg_ch;
                    pend_div_d = cfg.cfg_div;
                    pend_en_d  = cfg.cfg_en;
                    state_d    = PEND;
                    ready_d    = 1'b0;
                end
            end
            PEND: begin
                ready_d = 1'b0;
                if (tick_q) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Starting one short of the wrap makes the first post-reset cycle
            // see count 0, so the first tick lands PRE-1 cycles after release.
            pre_cnt_q <= PRE_LAST;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            ready_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            ready_q   <= ready_d;
        end
        pend_ch_q  <= pend_ch_d;
        pend_div_q <= pend_div_d;
        pend_en_q  <= pend_en_d;
    end

`ifdef CLKDIV_PHASE_SYNC_EN
    assign sync_clr = apply;
`else
    assign sync_clr = 1'b0;
`endif

    // An out-of-range channel number decodes to no load at all.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign load[i] = apply && (pend_ch_q == CH_W'(i));

        clkdiv_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick_q),
            .load     (load[i]),
            .load_div (pend_div_q),
            .load_en  (pend_en_q),
            .sync_clr (sync_clr),
            .out      (clkout[i])
        );
    end

    assign tick          = tick_q;
    assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
module tb_clkdiv_ctrl;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int PRE     = CLK_HZ / TICK_HZ;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: NCH=4 (2-bit channel field); instance 1: NCH=5 (3-bit field, so ch 5..7 are out of range)
    clkdiv_if #(.NCH(4), .DIV_W(DIV_W)) bus0 ();
    clkdiv_if #(.NCH(5), .DIV_W(DIV_W)) bus1 ();

    logic       tick0, tick1;
    logic [3:0] clkout0;
    logic [4:0] clkout1;

    logic             s_vld [2];
    logic [2:0]       s_ch  [2];
    logic [DIV_W-1:0] s_div [2];
    logic             s_en  [2];

    assign bus0.cfg_valid = s_vld[0];
    assign bus0.cfg_ch    = s_ch[0][1:0];
    assign bus0.cfg_div   = s_div[0];
    assign bus0.cfg_en    = s_en[0];
    assign bus1.cfg_valid = s_vld[1];
    assign bus1.cfg_ch    = s_ch[1];
    assign bus1.cfg_div   = s_div[1];
    assign bus1.cfg_en    = s_en[1];

    clkdiv_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NCH(4), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg(bus0), .tick(tick0), .clkout(clkout0));
    clkdiv_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NCH(5), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg(bus1), .tick(tick1), .clkout(clkout1));

    // ---------------- behavioural reference ----------------
    // Each channel is described by how many ticks it has counted since it was
    // last (re)started plus the output level it started from; the output is
    // that level flipped once per full half-period counted.
    int cyc = -1;
    int m_div  [2][8];
    int m_en   [2][8];
    int m_k    [2][8];
    int m_base [2][8];
    bit pend [2];
    int p_ch [2];
    int p_div [2];
    int p_en [2];

    int n_checks = 0;
    int n_err = 0;
    bit checking = 0;

    function automatic int nch_of(int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic logic exp_out(int i, int c);
        if (m_en[i][c] == 0 || m_div[i][c] == 0) return 1'b0;
        return 1'((m_base[i][c] + m_k[i][c] / m_div[i][c]) % 2);
    endfunction

    function automatic logic [7:0] exp_vec(int i);
        logic [7:0] v = '0;
        for (int c = 0; c < nch_of(i); c++) v[c] = exp_out(i, c);
        return v;
    endfunction

    function automatic logic exp_tick();
        return (cyc >= 0) && (cyc % PRE == PRE - 1);
    endfunction

    function automatic logic exp_rdy(int i);
        return (cyc >= 0) && !pend[i];
    endfunction

    function automatic logic rdy_of(int i);
        return (i == 0) ? bus0.cfg_ready : bus1.cfg_ready;
    endfunction

    always @(posedge clk) begin : model
        bit tk;
        bit rdy;
        bit app;
        int cur;
        if (!rst_n) begin
            cyc = -1;
            for (int i = 0; i < 2; i++) begin
                pend[i] = 0;
                for (int c = 0; c < 8; c++) begin
                    m_div[i][c] = DEF_DIV; m_en[i][c] = 1; m_k[i][c] = 0; m_base[i][c] = 0;
                end
            end
        end else begin
            tk = (cyc >= 0) && (cyc % PRE == PRE - 1);
            for (int i = 0; i < 2; i++) begin
                rdy = (cyc >= 0) && !pend[i];
                if (tk) begin
                    app = pend[i];
                    for (int c = 0; c < nch_of(i); c++) begin
                        if (app && p_ch[i] == c) begin
                            cur = exp_out(i, c);
                            m_div[i][c] = p_div[i];
                            m_en[i][c]  = p_en[i];
                            m_base[i][c] = (p_en[i] != 0 && p_div[i] != 0) ? cur : 0;
                            m_k[i][c] = 0;
                        end else if (m_en[i][c] != 0 && m_div[i][c] != 0) begin
                            m_k[i][c]++;
                        end
                    end
`ifdef CLKDIV_PHASE_SYNC_EN
                    if (app) begin
                        for (int c = 0; c < nch_of(i); c++) begin
                            m_base[i][c] = 0; m_k[i][c] = 0;
                        end
                    end
`endif
                    pend[i] = 0;
                end
                if (rdy && s_vld[i]) begin
                    pend[i]  = 1;
                    p_ch[i]  = (i == 0) ? int'(s_ch[i][1:0]) : int'(s_ch[i]);
                    p_div[i] = int'(s_div[i]);
                    p_en[i]  = int'(s_en[i]);
                end
            end
            cyc++;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // per-cycle comparison against the reference
    always @(negedge clk) begin
        if (checking) begin
            check("tick0", 8'(tick0), 8'(exp_tick()));
            check("tick1", 8'(tick1), 8'(exp_tick()));
            check("ready0", 8'(bus0.cfg_ready), 8'(exp_rdy(0)));
            check("ready1", 8'(bus1.cfg_ready), 8'(exp_rdy(1)));
            check("clkout0", 8'(clkout0), exp_vec(0));
            check("clkout1", 8'(clkout1), exp_vec(1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int c);
        int g = 0;
        while (cyc != c && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != c) begin
            n_err++;
            $display("FAIL wait_cyc: never reached cycle %0d", c);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
            $fatal(1, "cycle wait expired");
        end
    endtask

    task automatic do_write(input int i, input int ch, input int dv, input bit en);
        int g = 0;
        s_vld[i] = 1'b1;
        s_ch[i]  = 3'(ch);
        s_div[i] = DIV_W'(dv);
        s_en[i]  = en;
        while (rdy_of(i) !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (g >= 100) begin
            n_err++;
            $display("FAIL handshake inst %0d: ready %0b, expected 1", i, rdy_of(i));
        end
        @(negedge clk);
        s_vld[i] = 1'b0;
    endtask

    bit was_rdy [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_vld[i] = 0; s_ch[i] = '0; s_div[i] = '0; s_en[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1;
        check("rst tick0", 8'(tick0), 8'h00);
        check("rst clkout0", 8'(clkout0), 8'h00);
        check("rst ready0", 8'(bus0.cfg_ready), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("cyc0 ready0", 8'(bus0.cfg_ready), 8'h01);

`ifndef CLKDIV_PHASE_SYNC_EN
        wait_cyc(3);
        do_write(0, 1, 5, 1);
        check("cyc4 ready0", 8'(bus0.cfg_ready), 8'h00);
        wait_cyc(9);
        check("cyc9 ready0", 8'(bus0.cfg_ready), 8'h00);
        check("cyc9 tick0", 8'(tick0), 8'h01);
        wait_cyc(10);
        check("cyc10 ready0", 8'(bus0.cfg_ready), 8'h01);
        check("cyc10 tick0", 8'(tick0), 8'h00);
        wait_cyc(19);  check("cyc19 clkout0", 8'(clkout0), 8'h00);
        wait_cyc(20);  check("cyc20 clkout0", 8'(clkout0), 8'h0D);
        check("cyc20 clkout1", 8'(clkout1), 8'h1F);
        wait_cyc(40);  check("cyc40 clkout0", 8'(clkout0), 8'h00);
        wait_cyc(59);  check("cyc59 clkout0", 8'(clkout0), 8'h00);
        wait_cyc(60);  check("cyc60 clkout0", 8'(clkout0), 8'h0F);
        wait_cyc(100); check("cyc100 clkout0", 8'(clkout0), 8'h0F);
        wait_cyc(110); check("cyc110 clkout0", 8'(clkout0), 8'h0D);
        wait_cyc(160); check("cyc160 clkout0", 8'(clkout0), 8'h02);
        wait_cyc(163);
        do_write(0, 2, 2, 0);
        wait_cyc(170); check("ch2 off clkout0", 8'(clkout0), 8'h02);
        wait_cyc(180); check("cyc180 clkout0", 8'(clkout0), 8'h0B);
        wait_cyc(183);
        do_write(0, 3, 0, 1);
        wait_cyc(190); check("ch3 div0 clkout0", 8'(clkout0), 8'h03);
        wait_cyc(200); check("cyc200 clkout0", 8'(clkout0), 8'h02);
        wait_cyc(203);
        do_write(1, 7, 3, 1);
        check("oor ready1 low", 8'(bus1.cfg_ready), 8'h00);
        wait_cyc(210);
        check("oor ready1 back", 8'(bus1.cfg_ready), 8'h01);
        check("oor clkout1", 8'(clkout1), 8'h00);
        wait_cyc(220);
        check("oor clkout1 rise", 8'(clkout1), 8'h1F);
        check("cyc220 clkout0", 8'(clkout0), 8'h01);
`else
        wait_cyc(25);
        check("sync pre clkout0", 8'(clkout0), 8'h0F);
        do_write(0, 0, 3, 1);
        wait_cyc(30); check("sync clr clkout0", 8'(clkout0), 8'h00);
        wait_cyc(49); check("sync cyc49 clkout0", 8'(clkout0), 8'h00);
        wait_cyc(50); check("sync cyc50 clkout0", 8'(clkout0), 8'h0E);
        wait_cyc(60); check("sync cyc60 clkout0", 8'(clkout0), 8'h0F);
`endif

        // reset while a write is pending discards it
        do_write(0, 0, 7, 1);
        check("pend ready0", 8'(bus0.cfg_ready), 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("pend rst ready0", 8'(bus0.cfg_ready), 8'h00);
        check("pend rst clkout0", 8'(clkout0), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst ready0", 8'(bus0.cfg_ready), 8'h01);
        wait_cyc(20);
        check("post rst clkout0", 8'(clkout0), 8'h0F);
        check("post rst clkout1", 8'(clkout1), 8'h1F);

        // randomized writes on both instances with occasional resets
        was_rdy[0] = 0;
        was_rdy[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (s_vld[i] && was_rdy[i]) s_vld[i] = 1'b0;
                if (!s_vld[i] && $urandom_range(0, 19) == 0) begin
                    s_vld[i] = 1'b1;
                    s_ch[i]  = 3'($urandom_range(0, 7));
                    s_div[i] = DIV_W'($urandom_range(0, 6));
                    s_en[i]  = ($urandom_range(0, 4) != 0);
                end
            end
            if (rst_n && $urandom_range(0, 599) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            for (int i = 0; i < 2; i++) was_rdy[i] = rdy_of(i) && rst_n;
            @(negedge clk);
        end
        s_vld[0] = 1'b0;
        s_vld[1] = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
